cordic_rotvec_pipe: RTL and testbench

//  Parametrised pipelined CORDIC core, successor to the fixed 32-stage rotation-only pipeline.

---
 rtl/cordic_pkg.sv | 62 ++++++
 rtl/cordic_rv_stage.sv | 69 ++++++
 rtl/cordic_rotvec_pipe.sv | 130 +++++++++++++
 tb/tb_cordic_rotvec_pipe.sv | 301 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/cordic_pkg.sv
// Shared constants for the rotation/vectoring CORDIC pipeline: mode encodings,
// gain reference and the elaboration-time arctangent table.
package cordic_pkg;

    localparam logic CORDIC_ROT = 1'b0;
    localparam logic CORDIC_VEC = 1'b1;

    // CORDIC gain K ~= 1.6467602581 as an unsigned Q16 reference value.
    localparam int unsigned CORDIC_K_Q16 = 32'd107922;

    // round(atan(2^-i) * 2^32 / 2pi): angles as a fraction of a full turn.
    function automatic logic [31:0] cordic_atan_q32(input int unsigned i);
        logic [31:0] t;
        case (i)
            0:       t = 32'h2000_0000;
            1:       t = 32'h12E4_051E;
            2:       t = 32'h09FB_385B;
            3:       t = 32'h0511_11D4;
            4:       t = 32'h028B_0D43;
            5:       t = 32'h0145_D7E1;
            6:       t = 32'h00A2_F61E;
            7:       t = 32'h0051_7C55;
            8:       t = 32'h0028_BE53;
            9:       t = 32'h0014_5F2F;
            10:      t = 32'h000A_2F98;
            11:      t = 32'h0005_17CC;
            12:      t = 32'h0002_8BE6;
            13:      t = 32'h0001_45F3;
            14:      t = 32'h0000_A2FA;
            15:      t = 32'h0000_517D;
            16:      t = 32'h0000_28BE;
            17:      t = 32'h0000_145F;
            18:      t = 32'h0000_0A30;
            19:      t = 32'h0000_0518;
            20:      t = 32'h0000_028C;
            21:      t = 32'h0000_0146;
            22:      t = 32'h0000_00A3;
            23:      t = 32'h0000_0051;
            24:      t = 32'h0000_0029;
            25:      t = 32'h0000_0014;
            26:      t = 32'h0000_000A;
            27:      t = 32'h0000_0005;
            28:      t = 32'h0000_0003;
            29:      t = 32'h0000_0001;
            30:      t = 32'h0000_0001;
            default: t = 32'h0000_0000;
        endcase
        return t;
    endfunction

    // ATAN[i] rounded to an nz-bit binary angle (nz up to 32).
    function automatic logic [31:0] cordic_atan(input int unsigned i, input int unsigned nz);
        logic [63:0] t;
        t = 64'(cordic_atan_q32(i));
        if (nz >= 32) begin
            return cordic_atan_q32(i);
        end
        t = t + (64'd1 << (31 - nz));
        return 32'(t >> (32 - nz));
    endfunction

endpackage

// File: rtl/cordic_rv_stage.sv
// One registered CORDIC micro-rotation; the mode bit carried with the sample
// selects the rotation or vectoring direction rule.
module cordic_rv_stage
    import cordic_pkg::*;
#(
    parameter int unsigned W   = 18,
    parameter int unsigned NZ  = 16,
    parameter int unsigned IDX = 0
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic                 en,
    input  logic                 in_valid,
    input  logic                 in_mode,
    input  logic signed [W-1:0]  in_x,
    input  logic signed [W-1:0]  in_y,
    input  logic signed [NZ-1:0] in_z,
    output logic                 out_valid,
    output logic                 out_mode,
    output logic signed [W-1:0]  out_x,
    output logic signed [W-1:0]  out_y,
    output logic signed [NZ-1:0] out_z
);

    localparam logic signed [NZ-1:0] ATAN = NZ'(cordic_atan(IDX, NZ));

    logic                 d_pos;
    logic signed [W-1:0]  x_sh;
    logic signed [W-1:0]  y_sh;
    logic signed [W-1:0]  x_nxt;
    logic signed [W-1:0]  y_nxt;
    logic signed [NZ-1:0] z_nxt;

    // d = +1: rotation drives z toward zero, vectoring drives y toward zero.
    always_comb begin
        d_pos = ~in_z[NZ-1];
        if (in_mode == CORDIC_VEC) begin
            d_pos = in_y[W-1];
        end
        x_sh = in_x >>> IDX;
        y_sh = in_y >>> IDX;
        if (d_pos) begin
            x_nxt = in_x - y_sh;
            y_nxt = in_y + x_sh;
            z_nxt = in_z - ATAN;
        end else begin
            x_nxt = in_x + y_sh;
            y_nxt = in_y - x_sh;
            z_nxt = in_z + ATAN;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            out_valid <= 1'b0;
            out_mode  <= 1'b0;
            out_x     <= '0;
            out_y     <= '0;
            out_z     <= '0;
        end else if (en) begin
            out_valid <= in_valid;
            out_mode  <= in_mode;
            out_x     <= x_nxt;
            out_y     <= y_nxt;
            out_z     <= z_nxt;
        end
    end

endmodule

// File: rtl/cordic_rotvec_pipe.sv
// Pipelined CORDIC core, rotation or vectoring selected per sample, with a
// quadrant pre-rotation stage and a stall-all valid/ready pipeline.
module cordic_rotvec_pipe
    import cordic_pkg::*;
#(
    parameter int unsigned NXY  = 16,
    parameter int unsigned NZ   = 16,
    parameter int unsigned NSTG = 16
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic                  in_mode,
    input  logic signed [NXY-1:0] in_x,
    input  logic signed [NXY-1:0] in_y,
    input  logic signed [NZ-1:0]  in_z,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic                  out_mode,
    output logic signed [NXY+1:0] out_x,
    output logic signed [NXY+1:0] out_y,
    output logic signed [NZ-1:0]  out_z
);

    localparam int unsigned W = NXY + 2;
    localparam logic [NZ-1:0] Z_HALF = {1'b1, {(NZ-1){1'b0}}};

    logic                 adv;
    logic                 neg;
    logic signed [W-1:0]  x_ext;
    logic signed [W-1:0]  y_ext;
    logic signed [W-1:0]  p_x_nxt;
    logic signed [W-1:0]  p_y_nxt;
    logic signed [NZ-1:0] p_z_nxt;

    logic                 p_valid;
    logic                 p_mode;
    logic signed [W-1:0]  p_x;
    logic signed [W-1:0]  p_y;
    logic signed [NZ-1:0] p_z;

    logic                 sv [NSTG];
    logic                 sm [NSTG];
    logic signed [W-1:0]  sx [NSTG];
    logic signed [W-1:0]  sy [NSTG];
    logic signed [NZ-1:0] sz [NSTG];

    // Whole pipeline moves together unless the output is held.
    assign adv      = out_ready | ~out_valid;
    assign in_ready = adv;

    // Quadrant fold; -180deg and +180deg are the same MSB flip mod 2^NZ.
    always_comb begin
        x_ext = W'(in_x);
        y_ext = W'(in_y);
        neg   = in_z[NZ-1] ^ in_z[NZ-2];
        if (in_mode == CORDIC_VEC) begin
            neg = in_x[NXY-1];
        end
        p_x_nxt = neg ? -x_ext : x_ext;
        p_y_nxt = neg ? -y_ext : y_ext;
        p_z_nxt = neg ? (in_z ^ Z_HALF) : in_z;
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            p_valid <= 1'b0;
            p_mode  <= 1'b0;
            p_x     <= '0;
            p_y     <= '0;
            p_z     <= '0;
        end else if (adv) begin
            p_valid <= in_valid;
            p_mode  <= in_mode;
            p_x     <= p_x_nxt;
            p_y     <= p_y_nxt;
            p_z     <= p_z_nxt;
        end
    end

    for (genvar g = 0; g < NSTG; g++) begin : g_stg
        logic                 v_i;
        logic                 m_i;
        logic signed [W-1:0]  x_i;
        logic signed [W-1:0]  y_i;
        logic signed [NZ-1:0] z_i;

        if (g == 0) begin : g_first
            assign v_i = p_valid;
            assign m_i = p_mode;
            assign x_i = p_x;
            assign y_i = p_y;
            assign z_i = p_z;
        end else begin : g_next
            assign v_i = sv[g-1];
            assign m_i = sm[g-1];
            assign x_i = sx[g-1];
            assign y_i = sy[g-1];
            assign z_i = sz[g-1];
        end

        cordic_rv_stage #(
            .W   (W),
            .NZ  (NZ),
            .IDX (g)
        ) u_stage (
            .clk       (clk),
            .reset_n   (reset_n),
            .en        (adv),
            .in_valid  (v_i),
            .in_mode   (m_i),
            .in_x      (x_i),
            .in_y      (y_i),
            .in_z      (z_i),
            .out_valid (sv[g]),
            .out_mode  (sm[g]),
            .out_x     (sx[g]),
            .out_y     (sy[g]),
            .out_z     (sz[g])
        );
    end

    assign out_valid = sv[NSTG-1];
    assign out_mode  = sm[NSTG-1];
    assign out_x     = sx[NSTG-1];
    assign out_y     = sy[NSTG-1];
    assign out_z     = sz[NSTG-1];

endmodule

// File: tb/tb_cordic_rotvec_pipe.sv
// Scoreboard bench for cordic_rotvec_pipe: directed vectors, backpressure,
// mixed modes and mid-flight reset at NXY=16, NZ=16, NSTG=16.
module tb_cordic_rotvec_pipe;

    localparam int NXY  = 16;
    localparam int NZ   = 16;
    localparam int NSTG = 16;
    localparam int LAT  = NSTG + 1;
    localparam int ATAN_T [16] = '{8192, 4836, 2555, 1297, 651, 326, 163, 81,
                                   41, 20, 10, 5, 3, 1, 1, 0};

    typedef struct {
        bit mode;
        int x;
        int y;
        int z;
        bit lat;
        int cyc;
        bit hand;
        int hx;
        int hy;
        int hz;
        int tol;
    } exp_t;

    logic                  clk;
    logic                  reset_n;
    logic                  in_valid;
    logic                  in_ready;
    logic                  in_mode;
    logic signed [NXY-1:0] in_x;
    logic signed [NXY-1:0] in_y;
    logic signed [NZ-1:0]  in_z;
    logic                  out_valid;
    logic                  out_ready;
    logic                  out_mode;
    logic signed [NXY+1:0] out_x;
    logic signed [NXY+1:0] out_y;
    logic signed [NZ-1:0]  out_z;

    int   checks = 0;
    int   errors = 0;
    int   cyc_cnt = 0;
    int   bp_cnt = 0;
    bit   bp_rand = 0;
    bit   bp_win = 0;
    exp_t sb [$];

    cordic_rotvec_pipe #(.NXY(NXY), .NZ(NZ), .NSTG(NSTG)) dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_mode   (in_mode),
        .in_x      (in_x),
        .in_y      (in_y),
        .in_z      (in_z),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_mode  (out_mode),
        .out_x     (out_x),
        .out_y     (out_y),
        .out_z     (out_z)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc_cnt++;

    // Downstream: optional random stalls plus a fixed 5-cycle stall window.
    always @(posedge clk) begin
        #1;
        bp_cnt++;
        out_ready = 1'b1;
        if (bp_rand && $urandom_range(0, 3) == 0) out_ready = 1'b0;
        if (bp_win && bp_cnt >= 20 && bp_cnt <= 24) out_ready = 1'b0;
    end

    function automatic int iabs(input int v);
        return (v < 0) ? -v : v;
    endfunction

    function automatic exp_t model(input bit mode, input int x, input int y, input logic [15:0] z);
        exp_t        e;
        int          xx;
        int          yy;
        int          tx;
        logic [15:0] zz;
        bit          dpos;
        xx = x;
        yy = y;
        zz = z;
        if ((mode == 1'b0 && (zz[15] != zz[14])) || (mode == 1'b1 && xx < 0)) begin
            xx = -xx;
            yy = -yy;
            zz = zz + 16'h8000;
        end
        for (int i = 0; i < NSTG; i++) begin
            dpos = mode ? (yy < 0) : (zz[15] == 1'b0);
            if (dpos) begin
                tx = xx - (yy >>> i);
                yy = yy + (xx >>> i);
                zz = zz - 16'(ATAN_T[i]);
            end else begin
                tx = xx + (yy >>> i);
                yy = yy - (xx >>> i);
                zz = zz + 16'(ATAN_T[i]);
            end
            xx = tx;
        end
        e = '{default: 0};
        e.mode = mode;
        e.x = xx;
        e.y = yy;
        e.z = int'($signed(zz));
        return e;
    endfunction

    task automatic chk(input string name, input int act, input int exp_v);
        checks++;
        if (act != exp_v) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp_v, $time);
        end
    endtask

    // Monitor: handshake invariant every cycle, results popped on transfer.
    always @(negedge clk) begin
        exp_t e;
        int   zd;
        if (reset_n) begin
            checks++;
            if (in_ready !== !(out_valid && !out_ready)) begin
                errors++;
                $display("FAIL in_ready: got %b expected %b", in_ready, !(out_valid && !out_ready));
            end
            if (out_valid && out_ready) begin
                if (sb.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_output: x=%0d y=%0d z=%0d with empty scoreboard",
                             out_x, out_y, out_z);
                end else begin
                    e = sb.pop_front();
                    checks++;
                    if (out_mode !== e.mode || int'(out_x) != e.x || int'(out_y) != e.y
                        || int'(out_z) != e.z) begin
                        errors++;
                        $display("FAIL result: got m=%0d x=%0d y=%0d z=%0d expected m=%0d x=%0d y=%0d z=%0d",
                                 out_mode, out_x, out_y, out_z, e.mode, e.x, e.y, e.z);
                    end
                    if (e.lat) chk("latency", cyc_cnt - e.cyc, LAT);
                    if (e.hand) begin
                        zd = int'($signed(16'(int'(out_z) - e.hz)));
                        checks++;
                        if (iabs(int'(out_x) - e.hx) > e.tol || iabs(int'(out_y) - e.hy) > e.tol
                            || iabs(zd) > 2) begin
                            errors++;
                            $display("FAIL directed: got x=%0d y=%0d z=%0d expected x=%0d y=%0d z=%0d tol %0d",
                                     out_x, out_y, out_z, e.hx, e.hy, e.hz, e.tol);
                        end
                    end
                end
            end
        end
    end

    task automatic send(input bit m, input int x, input int y, input int z, input bit lat,
                        input bit hand, input int hx, input int hy, input int hz, input int tol);
        exp_t e;
        bit   done;
        in_valid = 1'b1;
        in_mode  = m;
        in_x     = 16'(x);
        in_y     = 16'(y);
        in_z     = 16'(z);
        done     = 1'b0;
        for (int k = 0; k < 200 && !done; k++) begin
            @(negedge clk);
            if (in_ready) begin
                e      = model(m, int'(in_x), int'(in_y), 16'(z));
                e.lat  = lat;
                e.cyc  = cyc_cnt;
                e.hand = hand;
                e.hx   = hx;
                e.hy   = hy;
                e.hz   = hz;
                e.tol  = tol;
                sb.push_back(e);
                done   = 1'b1;
            end
        end
        if (!done) chk("accept_timeout", 0, 1);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    task automatic drain();
        int k;
        k = 0;
        while (sb.size() != 0 && k < 500) begin
            @(posedge clk);
            k++;
        end
        if (sb.size() != 0) begin
            chk("drain_timeout", sb.size(), 0);
            sb.delete();
        end
        repeat (2) @(posedge clk);
        #1;
    endtask

    task automatic chk_cleared(input string tag);
        chk({tag, "_out_valid"}, int'(out_valid), 0);
        chk({tag, "_out_mode"}, int'(out_mode), 0);
        chk({tag, "_out_x"}, int'(out_x), 0);
        chk({tag, "_out_y"}, int'(out_y), 0);
        chk({tag, "_out_z"}, int'(out_z), 0);
        chk({tag, "_in_ready"}, int'(in_ready), 1);
    endtask

    initial begin
        reset_n   = 1'b0;
        in_valid  = 1'b0;
        in_mode   = 1'b0;
        in_x      = '0;
        in_y      = '0;
        in_z      = '0;
        out_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        reset_n = 1'b1;
        @(negedge clk);
        chk_cleared("reset");
        @(posedge clk);
        #1;

        // Directed vectors; expectations traced by hand through the 16 stages.
        send(1'b0, 19898, 0, 16'h2000, 1'b1, 1'b1, 23169, 23172, 0, 2);
        drain();
        send(1'b1, 10000, 10000, 0, 1'b1, 1'b1, 23291, -1, 16'h2000, 2);
        drain();
        send(1'b0, 19898, 0, 16'h6000, 1'b1, 1'b1, -23172, 23165, 0, 2);
        drain();
        send(1'b1, -10000, 0, 0, 1'b1, 1'b1, 16472, 0, 16'h8000, 2);
        drain();
        // Boundaries: -180deg rotation and negation of the most negative x.
        send(1'b0, 19898, 0, 16'h8000, 1'b1, 1'b1, -32768, 0, 0, 10);
        drain();
        send(1'b1, -32768, 0, 0, 1'b1, 1'b1, 53962, 0, 16'h8000, 10);
        drain();

        // 40 back-to-back samples under random and windowed stalls.
        bp_cnt  = 0;
        bp_win  = 1'b1;
        bp_rand = 1'b1;
        for (int i = 0; i < 40; i++) begin
            send(((i % 3) == 0), int'($signed(16'($urandom))), int'($signed(16'($urandom))),
                 int'($urandom_range(0, 65535)), 1'b0, 1'b0, 0, 0, 0, 0);
        end
        drain();
        bp_win  = 1'b0;
        bp_rand = 1'b0;
        repeat (2) @(posedge clk);
        #1;

        // Modes interleaved every cycle.
        for (int i = 0; i < 20; i++) begin
            send(i[0], 1000 * i - 9000, 12000 - 1100 * i, 3277 * i, 1'b0, 1'b0, 0, 0, 0, 0);
        end
        drain();

        // Reset with samples in flight; nothing stale may follow.
        for (int i = 0; i < 10; i++) begin
            send(i[0], 500 * i + 300, -700 * i, 4000 * i, 1'b0, 1'b0, 0, 0, 0, 0);
        end
        reset_n = 1'b0;
        sb.delete();
        @(posedge clk);
        #1;
        reset_n = 1'b1;
        @(negedge clk);
        chk_cleared("midreset");
        repeat (30) @(posedge clk);
        #1;
        send(1'b0, 19898, 0, 16'h2000, 1'b1, 1'b1, 23169, 23172, 0, 2);
        drain();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout: simulation did not complete");
        $fatal(1, "timeout");
    end

endmodule
